// File: rtl/mock_memory_pipelined.sv
// rtl/mock_memory_pipelined.sv - pipelined mock memory with W/X regions, fixed read latency and buffered responses
module mock_memory_pipelined #(
  parameter int N = 4,
  parameter int DATA_WIDTH = 16,
  parameter int BANKING_FACTOR = 1,
  parameter int ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR_W = 32'h0000_0000,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR_X = 32'h0000_1000,
  parameter int MEM_LATENCY = 2,
  parameter int RESP_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic                                 req_we,
  input  logic [ADDRESS_WIDTH-1:0]             req_addr,
  input  logic [BANKING_FACTOR*DATA_WIDTH-1:0] req_wdata,
  output logic                                 resp_valid,
  input  logic                                 resp_ready,
  output logic [BANKING_FACTOR*DATA_WIDTH-1:0] resp_data,
  output logic                                 resp_err
);
  localparam int TOTAL_ELEMS = N * N;
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SH = $clog2(BYTES);
  localparam int BW = BANKING_FACTOR * DATA_WIDTH;
  localparam int AW = ADDRESS_WIDTH;
  localparam int IW = (TOTAL_ELEMS > 1) ? $clog2(TOTAL_ELEMS) : 1;
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = $clog2(RESP_DEPTH + 1);

  logic [DATA_WIDTH-1:0] w_mem [TOTAL_ELEMS];
  logic [DATA_WIDTH-1:0] x_mem [TOTAL_ELEMS];

  logic          is_x;
  logic [AW-1:0] base;
  logic [AW-1:0] wi;
  logic [AW-1:0] wi_mod;
  logic          addr_err;
  logic [IW-1:0] bank_idx [BANKING_FACTOR];
  logic [BW-1:0] rd_word;

  // Erroneous addresses still read using the wrapped index so the bench sees deterministic data.
  always_comb begin
    is_x     = (req_addr >= BASE_ADDR_X);
    base     = is_x ? BASE_ADDR_X : BASE_ADDR_W;
    wi       = (req_addr - base) >> SH;
    wi_mod   = wi % AW'(TOTAL_ELEMS);
    addr_err = (req_addr < BASE_ADDR_W) || ((req_addr & AW'(BYTES - 1)) != '0) ||
               (wi >= AW'(TOTAL_ELEMS));
    rd_word  = '0;
    for (int b = 0; b < BANKING_FACTOR; b++) begin
      bank_idx[b] = IW'((wi_mod + AW'(b)) % AW'(TOTAL_ELEMS));
      rd_word[b*DATA_WIDTH +: DATA_WIDTH] = is_x ? x_mem[bank_idx[b]] : w_mem[bank_idx[b]];
    end
  end

  logic [CW-1:0] cnt;
  logic          accept;
  logic          rd_acc;
  logic          wr_acc;
  logic          push;
  logic          pop;

  assign req_ready = !rst && (cnt < CW'(RESP_DEPTH));
  assign accept    = req_valid && req_ready;
  assign rd_acc    = accept && !req_we;
  assign wr_acc    = accept && req_we && !addr_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TOTAL_ELEMS; i++) begin
        w_mem[i] <= DATA_WIDTH'((i % N) << 8);
        x_mem[i] <= DATA_WIDTH'(((i % N) << 8) + 1);
      end
    end else if (wr_acc) begin
      for (int b = 0; b < BANKING_FACTOR; b++) begin
        if (is_x) x_mem[bank_idx[b]] <= req_wdata[b*DATA_WIDTH +: DATA_WIDTH];
        else      w_mem[bank_idx[b]] <= req_wdata[b*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  logic          pipe_v [MEM_LATENCY];
  logic [BW-1:0] pipe_d [MEM_LATENCY];
  logic          pipe_e [MEM_LATENCY];

  // Stage 0 captures the array at acceptance; the last stage feeds the FIFO, giving MEM_LATENCY edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < MEM_LATENCY; s++) begin
        pipe_v[s] <= 1'b0;
        pipe_d[s] <= '0;
        pipe_e[s] <= 1'b0;
      end
    end else begin
      pipe_v[0] <= rd_acc;
      pipe_d[0] <= rd_word;
      pipe_e[0] <= addr_err;
      for (int s = 1; s < MEM_LATENCY; s++) begin
        pipe_v[s] <= pipe_v[s-1];
        pipe_d[s] <= pipe_d[s-1];
        pipe_e[s] <= pipe_e[s-1];
      end
    end
  end

  logic [BW-1:0] fifo_d [RESP_DEPTH];
  logic          fifo_e [RESP_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_cnt;

  assign push       = pipe_v[MEM_LATENCY-1];
  assign resp_valid = (fifo_cnt != '0);
  assign pop        = resp_valid && resp_ready;
  assign resp_data  = fifo_d[rd_ptr];
  assign resp_err   = fifo_e[rd_ptr];

  // The credit counter covers pipeline plus FIFO, so a push never finds the FIFO full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RESP_DEPTH; i++) begin
        fifo_d[i] <= '0;
        fifo_e[i] <= 1'b0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      cnt      <= '0;
    end else begin
      if (push) begin
        fifo_d[wr_ptr] <= pipe_d[MEM_LATENCY-1];
        fifo_e[wr_ptr] <= pipe_e[MEM_LATENCY-1];
        wr_ptr <= (wr_ptr == PW'(RESP_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(RESP_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      case ({rd_acc, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_mock_memory_pipelined.sv
// tb/tb_mock_memory_pipelined.sv - directed self-checking bench for mock_memory_pipelined
module tb_mock_memory_pipelined;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        resp_err;

  int checks = 0;
  int errors = 0;
  logic [32:0] q [$];
  time         tq [$];

  mock_memory_pipelined #(
    .N(4), .DATA_WIDTH(16), .BANKING_FACTOR(2), .ADDRESS_WIDTH(32),
    .BASE_ADDR_W(32'h0000_0000), .BASE_ADDR_X(32'h0000_1000),
    .MEM_LATENCY(2), .RESP_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      q.push_back({resp_err, resp_data});
      tq.push_back($time);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic we, input logic [31:0] a, input logic [31:0] d);
    int t = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("send_timeout", 64'(t), 64'(0));
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_q(input int n);
    int t = 0;
    while (q.size() < n && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("q_size", 64'(q.size()), 64'(n));
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_resp_data", 64'(resp_data), 64'(0));
    check("rst_resp_err", 64'(resp_err), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("post_rst_ready", 64'(req_ready), 64'(1));

    // Single read: latency of two edges
    send(1'b0, 32'h0000, 32'h0);
    @(negedge clk); check("lat_e0", 64'(resp_valid), 64'(0));
    @(negedge clk); check("lat_e1", 64'(resp_valid), 64'(0));
    @(negedge clk); check("lat_e2", 64'(resp_valid), 64'(1));
    check("single_data", 64'(resp_data), 64'h0100_0000);
    check("single_err", 64'(resp_err), 64'(0));
    resp_ready = 1'b1;
    wait_q(1);
    check("single_pop", 64'(q[0]), {31'd0, 1'b0, 32'h0100_0000});
    @(negedge clk); check("single_drained", 64'(resp_valid), 64'(0));
    q.delete(); tq.delete();

    // Back-to-back X reads, no bubbles
    send(1'b0, 32'h1000, 32'h0);
    send(1'b0, 32'h1002, 32'h0);
    send(1'b0, 32'h1004, 32'h0);
    send(1'b0, 32'h1006, 32'h0);
    wait_q(4);
    check("b2b_0", 64'(q[0]), {31'd0, 1'b0, 32'h0101_0001});
    check("b2b_1", 64'(q[1]), {31'd0, 1'b0, 32'h0201_0101});
    check("b2b_2", 64'(q[2]), {31'd0, 1'b0, 32'h0301_0201});
    check("b2b_3", 64'(q[3]), {31'd0, 1'b0, 32'h0001_0301});
    for (int i = 0; i < 3; i++) check("b2b_gap", 64'(tq[i+1] - tq[i]), 64'(10));
    q.delete(); tq.delete();

    // Backpressure: four credits, then stall until resp_ready
    resp_ready = 1'b0;
    send(1'b0, 32'h0000, 32'h0);
    send(1'b0, 32'h0002, 32'h0);
    send(1'b0, 32'h0004, 32'h0);
    send(1'b0, 32'h0006, 32'h0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h1000;
    check("bp_ready_low", 64'(req_ready), 64'(0));
    repeat (3) @(negedge clk);
    check("bp_ready_still_low", 64'(req_ready), 64'(0));
    check("bp_resp_valid", 64'(resp_valid), 64'(1));
    check("bp_head_stable", 64'(resp_data), 64'h0100_0000);
    resp_ready = 1'b1;
    send(1'b0, 32'h1000, 32'h0);
    send(1'b0, 32'h101E, 32'h0);
    wait_q(6);
    check("bp_0", 64'(q[0]), {31'd0, 1'b0, 32'h0100_0000});
    check("bp_1", 64'(q[1]), {31'd0, 1'b0, 32'h0200_0100});
    check("bp_2", 64'(q[2]), {31'd0, 1'b0, 32'h0300_0200});
    check("bp_3", 64'(q[3]), {31'd0, 1'b0, 32'h0000_0300});
    check("bp_4", 64'(q[4]), {31'd0, 1'b0, 32'h0101_0001});
    check("bp_5_wrap", 64'(q[5]), {31'd0, 1'b0, 32'h0001_0301});
    q.delete(); tq.delete();

    // Write then read-after-write
    send(1'b1, 32'h1000, 32'hBEEF_CAFE);
    send(1'b0, 32'h1000, 32'h0);
    send(1'b0, 32'h1002, 32'h0);
    wait_q(2);
    check("raw_0", 64'(q[0]), {31'd0, 1'b0, 32'hBEEF_CAFE});
    check("raw_1", 64'(q[1]), {31'd0, 1'b0, 32'h0201_BEEF});
    q.delete(); tq.delete();

    // Address errors and dropped write
    send(1'b0, 32'h0001, 32'h0);
    send(1'b0, 32'h0020, 32'h0);
    send(1'b1, 32'h0020, 32'h1111_2222);
    send(1'b0, 32'h0000, 32'h0);
    wait_q(3);
    check("err_misaligned", 64'(q[0][32]), 64'(1));
    check("err_range", 64'(q[1]), {31'd0, 1'b1, 32'h0100_0000});
    check("err_write_dropped", 64'(q[2]), {31'd0, 1'b0, 32'h0100_0000});
    q.delete(); tq.delete();

    // Reset with reads in flight after a write
    resp_ready = 1'b0;
    send(1'b1, 32'h1000, 32'h1234_5678);
    send(1'b0, 32'h1000, 32'h0);
    send(1'b0, 32'h1002, 32'h0);
    @(posedge clk);
    #1 check("pre_rst_valid", 64'(resp_valid), 64'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(resp_valid), 64'(0));
    check("mid_rst_ready", 64'(req_ready), 64'(0));
    check("mid_rst_data", 64'(resp_data), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    resp_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("no_stale_resp", 64'(q.size()), 64'(0));
    send(1'b0, 32'h1000, 32'h0);
    wait_q(1);
    check("restored_x0", 64'(q[0]), {31'd0, 1'b0, 32'h0101_0001});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mock_memory_pipelined.md
# mock_memory_pipelined

Behavioural memory model for TPU bench use that replaces the single-outstanding mock memory. It accepts one read or write per cycle over a valid/ready request channel and returns read data in order after a fixed, parametrised latency. Responses are buffered so the consumer can apply backpressure. Weight (W) and activation (X) regions are pattern-initialised, and the model flags bad addresses.

## Interface
- N, 4: matrix dimension; each region holds TOTAL_ELEMS = N*N words
- DATA_WIDTH, 16: word width in bits; must be a multiple of 8
- BANKING_FACTOR, 1: words transferred per beat
- ADDRESS_WIDTH, 32: byte-address width
- BASE_ADDR_W, 32'h0000_0000: W region base byte address
- BASE_ADDR_X, 32'h0000_1000: X region base byte address; must be greater than BASE_ADDR_W
- MEM_LATENCY, 2: read latency in cycles; must be 1 or more
- RESP_DEPTH, 4: maximum reads in flight (pipeline plus response FIFO); must be 1 or more

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request valid
- req_ready  out  1  request accepted on a clk edge where req_valid & req_ready
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDRESS_WIDTH  byte address of bank 0 word
- req_wdata  in  BANKING_FACTOR*DATA_WIDTH  write data; bank b in bits [b*DATA_WIDTH +: DATA_WIDTH]
- resp_valid  out  1  read response valid
- resp_ready  in  1  response consumed on a clk edge where resp_valid & resp_ready
- resp_data  out  BANKING_FACTOR*DATA_WIDTH  read data, same bank packing as req_wdata
- resp_err  out  1  address error for this response

## Operation
- Region selection: X if req_addr >= BASE_ADDR_X, otherwise W. Base = BASE_ADDR_X or BASE_ADDR_W accordingly.
- Word index: wi = (req_addr - base) >> log2(DATA_WIDTH/8). Bank b uses element (wi + b) mod TOTAL_ELEMS.
- Error: err = 1 if req_addr < BASE_ADDR_W, or the low log2(DATA_WIDTH/8) address bits are non-zero, or wi >= TOTAL_ELEMS.
  - Read data is still returned, using the wrapped index.
  - A write with err = 1 is dropped.
- Initial and reset contents:
  - W[i] = (i mod N) << 8
  - X[i] = ((i mod N) << 8) + 1
  - Asserting reset restores these contents.
- Write: updates all BANKING_FACTOR elements at the acceptance edge. A write produces no response.
- Read: samples the array at the acceptance edge.
  - A read accepted after a write observes the written data.
  - One request per cycle, so reads and writes never collide.
- Ordering: responses are returned strictly in acceptance order.
- Credit counter cnt, range 0..RESP_DEPTH:
  - +1 on read acceptance.
  - −1 on response handshake.
  - Both in the same cycle leaves cnt unchanged.
- req_ready = !rst && (cnt < RESP_DEPTH). This applies to writes as well.
- Response FIFO: RESP_DEPTH entries, occupancy never exceeds RESP_DEPTH (guaranteed by the credit counter).
  - resp_valid = FIFO not empty.
  - resp_data and resp_err show the FIFO head.
  - resp_data and resp_err are held stable while resp_valid & !resp_ready.

## Timing
- Reset values: resp_valid = 0, resp_data = 0, resp_err = 0, cnt = 0, pipeline and FIFO empty, req_ready = 0 while rst is high.
- Reset mid-operation: all in-flight and buffered reads are discarded immediately. No stale response may appear after reset.
- Latency, for a read accepted at edge k:
  - With an empty FIFO, resp_valid and data are visible after edge k + MEM_LATENCY.
  - If the FIFO is non-empty, the response is delayed only by the FIFO.
- Throughput: back-to-back reads with resp_ready held at 1 give one response per cycle, with no bubbles.
- Credit release: resp_ready at edge j frees a credit, so req_ready can rise after edge j.
- Backpressure: with resp_ready held at 0, exactly RESP_DEPTH reads are accepted, then req_ready drops.
  - The pipeline never drops or overwrites data.
- resp_valid and resp_data are registered outputs with no combinational path from req_*.
- req_ready depends only on registered state and rst.

## Test plan
All scenarios use N=4, DATA_WIDTH=16, BANKING_FACTOR=2, MEM_LATENCY=2, RESP_DEPTH=4; resp_data is written as {bank1, bank0}.
- Single read at 0x0000 -> resp_valid two cycles later, resp_data = {0x0100, 0x0000}, resp_err = 0.
- Reads at 0x1000, 0x1002, 0x1004, 0x1006 on consecutive cycles with resp_ready = 1 -> four consecutive responses:
  - {0x0101, 0x0001}
  - {0x0201, 0x0101}
  - {0x0301, 0x0201}
  - {0x0001, 0x0301}
- resp_ready = 0 with 6 reads offered -> 4 accepted and req_ready = 0. Then set resp_ready = 1 -> remaining 2 accepted, and all 6 responses return in order and intact.
- Write 0x1000 with {0xBEEF, 0xCAFE}, then read 0x1000 and 0x1002 -> {0xBEEF, 0xCAFE} and {0x0201, 0xBEEF}.
- Read 0x0001 -> resp_err = 1. Read 0x0020 -> resp_err = 1, data {0x0100, 0x0000}. Write 0x0020 -> memory unchanged.
- Assert rst with 2 reads in flight after a write -> resp_valid = 0 at once and no responses after release. A read at 0x1000 then returns {0x0101, 0x0001}.
